// File: rtl/tpiu_frame_decoder.sv
// CoreSight TPIU formatter frame decoder: walks 16-byte frames into (ID, byte) pairs.
// Optional ID filter input IdMatch is enabled by defining TPIU_IDFILTER_EN.
module tpiu_frame_decoder #(
    parameter bit         EMIT_NULL = 1'b0,
    parameter logic [6:0] RESET_ID  = 7'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] Frame,
    input  logic         FrameReady,
    output logic         FrameNext,
    output logic [7:0]   DataOut,
    output logic [6:0]   IdOut,
    output logic         DataValid,
    input  logic         DataReady,
`ifdef TPIU_IDFILTER_EN
    input  logic [6:0]   IdMatch,
`endif
    output logic         Busy
);

    typedef enum logic {IDLE, WALK} state_t;

    state_t       state, state_nx;
    logic [127:0] frame_reg;
    logic [3:0]   slot;
    logic [6:0]   cur_id;
    logic [6:0]   pend_id;
    logic         pend_vld;
    logic         next_d;

    logic         capture;
    logic         step;
    logic         last;
    logic [7:0]   byte_cur;
    logic         aux_bit;
    logic         is_id;
    logic         id_pass;
    logic         emit;
    logic [7:0]   emit_data;

`ifdef TPIU_IDFILTER_EN
    assign id_pass = (IdMatch == 7'd0) || (cur_id == IdMatch);
`else
    assign id_pass = 1'b1;
`endif

    // Slot decode: byte 15 carries one aux bit per even slot pair.
    always_comb begin
        capture   = (state == IDLE) && FrameReady && !FrameNext && !next_d;
        step      = (state == WALK) && (!DataValid || DataReady);
        last      = (slot == 4'd14);
        byte_cur  = frame_reg[{slot, 3'b000} +: 8];
        aux_bit   = frame_reg[{4'b1111, slot[3:1]}];
        is_id     = !slot[0] && byte_cur[0];
        emit_data = slot[0] ? byte_cur : {byte_cur[7:1], aux_bit};
        emit      = step && !is_id && ((cur_id != 7'd0) || EMIT_NULL) && id_pass;

        state_nx = state;
        case (state)
            IDLE:    if (capture) state_nx = WALK;
            WALK:    if (step && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Capture / slot walk / registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            FrameNext <= 1'b0;
            next_d    <= 1'b0;
            frame_reg <= '0;
            slot      <= 4'd0;
            Busy      <= 1'b0;
            cur_id    <= RESET_ID;
            pend_id   <= 7'd0;
            pend_vld  <= 1'b0;
            DataValid <= 1'b0;
            DataOut   <= 8'd0;
            IdOut     <= 7'd0;
        end else begin
            FrameNext <= capture;
            next_d    <= FrameNext;
            if (capture) begin
                frame_reg <= Frame;
                slot      <= 4'd0;
                Busy      <= 1'b1;
            end
            if (step) begin
                slot <= slot + 4'd1;
                if (last) Busy <= 1'b0;
                if (is_id) begin
                    // A delayed switch on slot 14 has no odd slot to wait for, so it lands now.
                    if (aux_bit && !last) begin
                        pend_vld <= 1'b1;
                        pend_id  <= byte_cur[7:1];
                    end else begin
                        cur_id <= byte_cur[7:1];
                    end
                end else if (slot[0] && pend_vld) begin
                    cur_id   <= pend_id;
                    pend_vld <= 1'b0;
                end
            end
            if (emit) begin
                DataValid <= 1'b1;
                DataOut   <= emit_data;
                IdOut     <= cur_id;
            end else if (DataReady) begin
                DataValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpiu_frame_decoder.sv
// Bench for tpiu_frame_decoder: two instances (EMIT_NULL=0/1) checked against a frame-level model.
module tb_tpiu_frame_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         DataReady = 1'b1;
    logic [127:0] frame0 = '0, frame1 = '0;
    logic         ready0 = 1'b0, ready1 = 1'b0;
    logic         fn0, fn1, dv0, dv1, busy0, busy1;
    logic [7:0]   do0, do1;
    logic [6:0]   id0, id1;
`ifdef TPIU_IDFILTER_EN
    logic [6:0]   id_match = 7'd0;
`endif

    tpiu_frame_decoder #(.EMIT_NULL(1'b0), .RESET_ID(7'd0)) dut0 (
        .clk(clk), .rst(rst), .Frame(frame0), .FrameReady(ready0), .FrameNext(fn0),
        .DataOut(do0), .IdOut(id0), .DataValid(dv0), .DataReady(DataReady),
`ifdef TPIU_IDFILTER_EN
        .IdMatch(id_match),
`endif
        .Busy(busy0));

    tpiu_frame_decoder #(.EMIT_NULL(1'b1), .RESET_ID(7'd0)) dut1 (
        .clk(clk), .rst(rst), .Frame(frame1), .FrameReady(ready1), .FrameNext(fn1),
        .DataOut(do1), .IdOut(id1), .DataValid(dv1), .DataReady(DataReady),
`ifdef TPIU_IDFILTER_EN
        .IdMatch(id_match),
`endif
        .Busy(busy1));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [127:0] fq0[$], fq1[$];
    logic [14:0]  exp0[$], exp1[$], got0[$], got1[$];
    logic [6:0]   mcur0 = 7'd0, mcur1 = 7'd0;
    logic [14:0]  m_res[15];
    int           m_n;
    int           fn_cnt0 = 0, fn_last0 = -1000, fn_min0 = 1000;

    // Frame-level model: returns the ordered (id,data) pairs a frame yields.
    task automatic model_frame(input logic [127:0] f, input bit en, inout logic [6:0] cur);
        logic [7:0] aux, b, d;
        bit         pend;
        logic [6:0] pid;
        aux = f[127:120];
        pend = 1'b0;
        pid = 7'd0;
        m_n = 0;
        for (int s = 0; s < 15; s++) begin
            b = f[s*8 +: 8];
            if (s % 2 == 0 && b[0]) begin
                if (aux[s/2]) begin pend = 1'b1; pid = b[7:1]; end
                else cur = b[7:1];
            end else begin
                d = (s % 2 == 0) ? {b[7:1], aux[s/2]} : b;
                if (cur != 7'd0 || en) begin m_res[m_n] = {cur, d}; m_n++; end
                if (s % 2 == 1 && pend) begin cur = pid; pend = 1'b0; end
            end
        end
        if (pend) cur = pid;
    endtask

    task automatic push_frame(input logic [127:0] f);
        fq0.push_back(f);
        fq1.push_back(f);
        frame0 = fq0[0]; ready0 = 1'b1;
        frame1 = fq1[0]; ready1 = 1'b1;
    endtask

    task automatic cycle();
        bit rst_e, pv0, pv1, pb0, pb1, pf0, pf1, pr;
        logic [14:0] pd0, pd1, e;
        logic [127:0] f;
        rst_e = rst;
        pr = DataReady;
        if (dv0 && DataReady && !rst) begin
            checks++;
            got0.push_back({id0, do0});
            if (exp0.size() == 0) begin
                errors++; $display("FAIL out0_unexpected got=%h required=none", {id0, do0});
            end else begin
                e = exp0.pop_front();
                if ({id0, do0} !== e) begin errors++; $display("FAIL out0 got=%h required=%h", {id0, do0}, e); end
            end
        end
        if (dv1 && DataReady && !rst) begin
            checks++;
            got1.push_back({id1, do1});
            if (exp1.size() == 0) begin
                errors++; $display("FAIL out1_unexpected got=%h required=none", {id1, do1});
            end else begin
                e = exp1.pop_front();
                if ({id1, do1} !== e) begin errors++; $display("FAIL out1 got=%h required=%h", {id1, do1}, e); end
            end
        end
        pv0 = dv0; pv1 = dv1; pd0 = {id0, do0}; pd1 = {id1, do1};
        pb0 = busy0; pb1 = busy1; pf0 = fn0; pf1 = fn1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst_e) begin
            exp0.delete(); exp1.delete();
            mcur0 = 7'd0; mcur1 = 7'd0;
        end else begin
            if (pv0 && !pr) begin
                checks++;
                if (dv0 !== 1'b1 || {id0, do0} !== pd0) begin
                    errors++; $display("FAIL hold0 got=%b/%h required=1/%h", dv0, {id0, do0}, pd0);
                end
            end
            if (pv1 && !pr) begin
                checks++;
                if (dv1 !== 1'b1 || {id1, do1} !== pd1) begin
                    errors++; $display("FAIL hold1 got=%b/%h required=1/%h", dv1, {id1, do1}, pd1);
                end
            end
            if (fn0 === 1'b1) begin
                checks++;
                if (pb0 !== 1'b0 || pf0 !== 1'b0) begin
                    errors++; $display("FAIL next0_guard busy_prev=%b next_prev=%b required=0/0", pb0, pf0);
                end
                fn_cnt0++;
                if (cyc - fn_last0 < fn_min0) fn_min0 = cyc - fn_last0;
                fn_last0 = cyc;
                if (fq0.size() == 0) begin
                    errors++; $display("FAIL next0_spurious got=pulse required=none");
                end else begin
                    f = fq0.pop_front();
                    model_frame(f, 1'b0, mcur0);
                    for (int i = 0; i < m_n; i++) exp0.push_back(m_res[i]);
                end
            end
            if (fn1 === 1'b1) begin
                checks++;
                if (pb1 !== 1'b0 || pf1 !== 1'b0) begin
                    errors++; $display("FAIL next1_guard busy_prev=%b next_prev=%b required=0/0", pb1, pf1);
                end
                if (fq1.size() == 0) begin
                    errors++; $display("FAIL next1_spurious got=pulse required=none");
                end else begin
                    f = fq1.pop_front();
                    model_frame(f, 1'b1, mcur1);
                    for (int i = 0; i < m_n; i++) exp1.push_back(m_res[i]);
                end
            end
        end
        frame0 = (fq0.size() != 0) ? fq0[0] : '0;
        ready0 = (fq0.size() != 0);
        frame1 = (fq1.size() != 0) ? fq1[0] : '0;
        ready1 = (fq1.size() != 0);
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n = 0;
        while ((fq0.size() != 0 || fq1.size() != 0 || busy0 || busy1 || dv0 || dv1 || fn0 || fn1)
               && n < budget) begin
            DataReady = rnd ? 1'($urandom % 2) : 1'b1;
            cycle();
            n++;
        end
        DataReady = 1'b1;
        checks++;
        if (n >= budget) begin errors++; $display("FAIL drain_timeout got=%0d cycles required<%0d", n, budget); end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++; $display("FAIL leftover got=%0d/%0d required=0/0", exp0.size(), exp1.size());
        end
    endtask

    function automatic logic [127:0] data_frame(input logic [7:0] b0, input logic [7:0] aux);
        logic [127:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        for (int s = 2; s < 15; s += 2) f[s*8] = 1'b0;
        f[7:0] = b0;
        f[127:120] = aux;
        return f;
    endfunction

    task automatic test_reset();
        rst = 1'b1; DataReady = 1'b1;
        cycle(); cycle();
        checks++;
        if ({fn0, dv0, do0, id0, busy0} !== 18'd0) begin
            errors++; $display("FAIL reset0 got=%h required=0", {fn0, dv0, do0, id0, busy0});
        end
        checks++;
        if ({fn1, dv1, do1, id1, busy1} !== 18'd0) begin
            errors++; $display("FAIL reset1 got=%h required=0", {fn1, dv1, do1, id1, busy1});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [127:0] f = '0;
        f[7:0] = 8'h03;
        for (int i = 1; i < 15; i++) f[i*8 +: 8] = 8'(i * 16);
        got0.delete(); fn_cnt0 = 0;
        push_frame(f);
        drain(1'b0, 200);
        checks++;
        if (got0.size() != 14) begin errors++; $display("FAIL basic_count got=%0d required=14", got0.size()); end
        for (int i = 0; i < 14 && i < got0.size(); i++) begin
            checks++;
            if (got0[i] !== {7'd1, 8'(16 * (i + 1))}) begin
                errors++; $display("FAIL basic_byte%0d got=%h required=%h", i, got0[i], {7'd1, 8'(16 * (i + 1))});
            end
        end
        checks++;
        if (fn_cnt0 != 1) begin errors++; $display("FAIL basic_pulses got=%0d required=1", fn_cnt0); end
    endtask

    task automatic test_delayed_id();
        logic [127:0] f;
        for (int i = 0; i < 15; i++) f[i*8 +: 8] = 8'h22;
        f[23:16] = 8'h05;
        f[127:120] = 8'h02;
        got0.delete();
        push_frame(f);
        drain(1'b0, 200);
        checks++;
        if (got0.size() != 14) begin
            errors++; $display("FAIL delay_count got=%0d required=14", got0.size());
        end else begin
            checks++;
            if (got0[1] !== {7'd1, 8'h22}) begin errors++; $display("FAIL delay_b1 got=%h required=%h", got0[1], {7'd1, 8'h22}); end
            checks++;
            if (got0[2] !== {7'd1, 8'h22}) begin errors++; $display("FAIL delay_b3 got=%h required=%h", got0[2], {7'd1, 8'h22}); end
            checks++;
            if (got0[3] !== {7'd2, 8'h22}) begin errors++; $display("FAIL delay_b4 got=%h required=%h", got0[3], {7'd2, 8'h22}); end
            checks++;
            if (got0[13] !== {7'd2, 8'h22}) begin errors++; $display("FAIL delay_b14 got=%h required=%h", got0[13], {7'd2, 8'h22}); end
        end
    endtask

    task automatic test_aux_bit();
        logic [127:0] f;
        logic [7:0]   want;
        for (int a = 0; a < 2; a++) begin
            f = '0;
            f[7:0] = 8'h03;
            f[39:32] = 8'h40;
            f[127:120] = (a == 0) ? 8'h04 : 8'h00;
            want = (a == 0) ? 8'h41 : 8'h40;
            got0.delete();
            push_frame(f);
            drain(1'b0, 200);
            checks++;
            if (got0.size() < 4 || got0[3] !== {7'd1, want}) begin
                errors++; $display("FAIL aux%0d got=%h required=%h", a, (got0.size() < 4) ? 15'h7fff : got0[3], {7'd1, want});
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        push_frame(data_frame(8'h0B, 8'h00));
        push_frame(data_frame(8'h0D, 8'h00));
        got0.delete();
        DataReady = 1'b1;
        while (got0.size() < 3 && n < 60) begin cycle(); n++; end
        DataReady = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (dv0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++; $display("FAIL stall_state got=%b/%b required=1/1", dv0, busy0);
        end
        drain(1'b0, 300);
        checks++;
        if (got0.size() != 28) begin errors++; $display("FAIL stall_count got=%0d required=28", got0.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        DataReady = 1'b1;
        push_frame(data_frame(8'h03, 8'h00));
        while (fn0 !== 1'b1 && n < 20) begin cycle(); n++; end
        checks++;
        if (fn0 !== 1'b1) begin errors++; $display("FAIL rstmid_capture got=%b required=1", fn0); end
        for (int i = 0; i < 7; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({fn0, dv0, do0, id0, busy0} !== 18'd0 || {fn1, dv1, do1, id1, busy1} !== 18'd0) begin
            errors++; $display("FAIL rstmid_outputs got=%h/%h required=0/0",
                               {fn0, dv0, do0, id0, busy0}, {fn1, dv1, do1, id1, busy1});
        end
        got0.delete(); got1.delete();
        push_frame(data_frame(8'h01, 8'($urandom)));
        drain(1'b0, 200);
        checks++;
        if (got0.size() != 0) begin errors++; $display("FAIL null_dropped got=%0d required=0", got0.size()); end
        checks++;
        if (got1.size() != 14) begin errors++; $display("FAIL null_emitted got=%0d required=14", got1.size()); end
        for (int i = 0; i < got1.size(); i++) begin
            checks++;
            if (got1[i][14:8] !== 7'd0) begin errors++; $display("FAIL null_id%0d got=%h required=0", i, got1[i][14:8]); end
        end
    endtask

    task automatic test_back_to_back();
        got0.delete(); got1.delete();
        fn_cnt0 = 0; fn_last0 = -1000; fn_min0 = 1000;
        DataReady = 1'b1;
        push_frame(data_frame({7'(1 + $urandom % 120), 1'b1}, 8'($urandom) & 8'hFE));
        push_frame(data_frame(8'hFF, 8'($urandom) & 8'hFE));
        push_frame(data_frame({7'(1 + $urandom % 120), 1'b1}, 8'($urandom) & 8'hFE));
        drain(1'b0, 400);
        checks++;
        if (fn_cnt0 != 3) begin errors++; $display("FAIL b2b_pulses got=%0d required=3", fn_cnt0); end
        checks++;
        if (fn_min0 < 16) begin errors++; $display("FAIL b2b_spacing got=%0d required>=16", fn_min0); end
        checks++;
        if (got0.size() != 42 || got1.size() != 42) begin
            errors++; $display("FAIL b2b_count got=%0d/%0d required=42/42", got0.size(), got1.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) push_frame({$urandom, $urandom, $urandom, $urandom});
        drain(1'b1, 3000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_id();
        test_aux_bit();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
